// File: rtl/onehot_decoder_scan.sv
// Registered binary-to-one-hot decoder with DIRECT, HOLD, SCAN and OFF modes.
// Scan mode sweeps the one-hot bit across all outputs with a built-in step divider.
module onehot_decoder_scan #(
    parameter int SEL_W     = 3,
    parameter int SCAN_DIV  = 4,
    parameter int ALL_ON_EN = 0
) (
    input  logic                    sys_clk,
    input  logic                    sys_rst,
    input  logic [1:0]              mode,
    input  logic [SEL_W-1:0]        sel,
    input  logic                    sel_vld,
    output logic [(1<<SEL_W)-1:0]   out_onehot,
    output logic                    out_vld,
    output logic [SEL_W-1:0]        scan_idx,
    output logic                    scan_wrap
);

    localparam int OUT_W = 1 << SEL_W;
    localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(SCAN_DIV - 1);

    typedef enum logic [1:0] {
        MODE_DIRECT = 2'b00,
        MODE_HOLD   = 2'b01,
        MODE_SCAN   = 2'b10,
        MODE_OFF    = 2'b11
    } mode_e;

    mode_e              mode_cur;
    mode_e              mode_q;
    logic [DIV_W-1:0]   div_cnt;

    logic [OUT_W-1:0]   onehot_d;
    logic               vld_d;
    logic [SEL_W-1:0]   idx_d;
    logic               wrap_d;
    logic [DIV_W-1:0]   div_d;
    logic [SEL_W-1:0]   idx_inc;

    assign mode_cur = mode_e'(mode);
    assign idx_inc  = scan_idx + 1'b1;

    function automatic logic [OUT_W-1:0] decode(input logic [SEL_W-1:0] code);
        logic [OUT_W-1:0] res;
        if ((ALL_ON_EN != 0) && (&code))
            res = '1;
        else
            res = OUT_W'(1) << code;
        return res;
    endfunction

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path leaves a latch.
        onehot_d = out_onehot;
        vld_d    = 1'b0;
        idx_d    = scan_idx;
        wrap_d   = 1'b0;
        div_d    = div_cnt;

        case (mode_cur)
            MODE_DIRECT: begin
                if (sel_vld) begin
                    onehot_d = decode(sel);
                    vld_d    = 1'b1;
                end
            end
            MODE_HOLD: ;
            MODE_SCAN: begin
                // Entering SCAN from any other mode always restarts the sweep at index 0.
                if (mode_q != MODE_SCAN) begin
                    idx_d    = '0;
                    div_d    = '0;
                    onehot_d = OUT_W'(1);
                    vld_d    = 1'b1;
                end else if (div_cnt == DIV_MAX) begin
                    div_d    = '0;
                    idx_d    = idx_inc;
                    onehot_d = OUT_W'(1) << idx_inc;
                    vld_d    = 1'b1;
                    wrap_d   = &scan_idx;
                end else begin
                    div_d    = div_cnt + 1'b1;
                end
            end
            MODE_OFF: begin
                onehot_d = '0;
                idx_d    = '0;
                div_d    = '0;
            end
            default: ;
        endcase
    end

    // NOTE: state updates use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            out_onehot <= '0;
            out_vld    <= 1'b0;
            scan_idx   <= '0;
            scan_wrap  <= 1'b0;
            div_cnt    <= '0;
            mode_q     <= MODE_OFF;
        end else begin
            out_onehot <= onehot_d;
            out_vld    <= vld_d;
            scan_idx   <= idx_d;
            scan_wrap  <= wrap_d;
            div_cnt    <= div_d;
            mode_q     <= mode_cur;
        end
    end

endmodule

// File: tb/tb_onehot_decoder_scan.sv
// Directed bench for onehot_decoder_scan: one instance with SCAN_DIV=4/ALL_ON_EN=0,
// one with SCAN_DIV=1/ALL_ON_EN=1, both driven by the same stimulus.
module tb_onehot_decoder_scan;

    localparam logic [1:0] M_DIRECT = 2'b00;
    localparam logic [1:0] M_HOLD   = 2'b01;
    localparam logic [1:0] M_SCAN   = 2'b10;
    localparam logic [1:0] M_OFF    = 2'b11;

    logic       sys_clk = 1'b0;
    logic       sys_rst;
    logic [1:0] mode;
    logic [2:0] sel;
    logic       sel_vld;

    logic [7:0] a_out, b_out;
    logic       a_vld, b_vld;
    logic [2:0] a_idx, b_idx;
    logic       a_wrap, b_wrap;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 sys_clk = ~sys_clk;

    onehot_decoder_scan #(.SEL_W(3), .SCAN_DIV(4), .ALL_ON_EN(0)) dut_a (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .mode(mode), .sel(sel), .sel_vld(sel_vld),
        .out_onehot(a_out), .out_vld(a_vld), .scan_idx(a_idx), .scan_wrap(a_wrap)
    );

    onehot_decoder_scan #(.SEL_W(3), .SCAN_DIV(1), .ALL_ON_EN(1)) dut_b (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .mode(mode), .sel(sel), .sel_vld(sel_vld),
        .out_onehot(b_out), .out_vld(b_vld), .scan_idx(b_idx), .scan_wrap(b_wrap)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    initial begin
        logic [7:0] exp_a_out;
        logic [2:0] exp_a_idx;

        sys_rst = 1'b1;
        mode    = M_OFF;
        sel     = '0;
        sel_vld = 1'b0;
        tick();
        tick();
        check("rst_out", a_out, 8'h00);
        check("rst_vld", a_vld, 1'b0);
        check("rst_idx", a_idx, 3'd0);
        check("rst_wrap", a_wrap, 1'b0);
        sys_rst = 1'b0;

        // Single decode, switching into DIRECT with sel_vld in the same cycle.
        mode = M_DIRECT; sel = 3'd5; sel_vld = 1'b1;
        tick();
        check("dir5_out", a_out, 8'h20);
        check("dir5_vld", a_vld, 1'b1);
        sel_vld = 1'b0; sel = 3'd2;
        tick();
        check("dir5_hold_out", a_out, 8'h20);
        check("dir5_hold_vld", a_vld, 1'b0);

        // Back-to-back codes 0, 1, 7.
        sel_vld = 1'b1; sel = 3'd0;
        tick();
        check("b2b0_a", a_out, 8'h01); check("b2b0_b", b_out, 8'h01); check("b2b0_vld", a_vld, 1'b1);
        sel = 3'd1;
        tick();
        check("b2b1_a", a_out, 8'h02); check("b2b1_b", b_out, 8'h02); check("b2b1_vld", a_vld, 1'b1);
        sel = 3'd7;
        tick();
        check("b2b7_a", a_out, 8'h80); check("b2b7_b_allon", b_out, 8'hFF);
        check("b2b7_vld", a_vld, 1'b1); check("b2b7_vld_b", b_vld, 1'b1);
        sel_vld = 1'b0;

        // OFF then SCAN entry; full sweep on both instances.
        mode = M_OFF;
        tick();
        check("off_out", a_out, 8'h00);
        check("off_vld", a_vld, 1'b0);
        mode = M_SCAN;
        tick();
        check("entry_a_out", a_out, 8'h01); check("entry_a_vld", a_vld, 1'b1); check("entry_a_idx", a_idx, 3'd0);
        check("entry_b_out", b_out, 8'h01); check("entry_b_vld", b_vld, 1'b1);
        exp_a_out = 8'h01;
        for (int c = 1; c <= 32; c++) begin
            tick();
            if (c % 4 == 0) begin
                exp_a_idx = 3'((c / 4) % 8);
                exp_a_out = 8'h01 << exp_a_idx;
                check("scan4_vld", a_vld, 1'b1);
                check("scan4_idx", a_idx, exp_a_idx);
            end else begin
                check("scan4_vld", a_vld, 1'b0);
            end
            check("scan4_out", a_out, exp_a_out);
            check("scan4_wrap", a_wrap, (c == 32) ? 1'b1 : 1'b0);
            check("scan1_out", b_out, 8'h01 << (c % 8));
            check("scan1_vld", b_vld, 1'b1);
            check("scan1_wrap", b_wrap, (c % 8 == 0) ? 1'b1 : 1'b0);
        end

        // HOLD at scan_idx 3, then DIRECT idle, then SCAN restart.
        mode = M_OFF;
        tick();
        mode = M_SCAN;
        tick();
        for (int c = 1; c <= 12; c++) tick();
        check("pre_hold_idx", a_idx, 3'd3);
        check("pre_hold_out", a_out, 8'h08);
        mode = M_HOLD; sel_vld = 1'b1; sel = 3'd6;
        for (int c = 0; c < 10; c++) begin
            tick();
            check("hold_out", a_out, 8'h08);
            check("hold_vld", a_vld, 1'b0);
            check("hold_idx", a_idx, 3'd3);
        end
        mode = M_DIRECT; sel_vld = 1'b0;
        tick();
        check("hold_dir_out", a_out, 8'h08);
        check("hold_dir_idx", a_idx, 3'd3);
        mode = M_SCAN;
        tick();
        check("reentry_out", a_out, 8'h01);
        check("reentry_vld", a_vld, 1'b1);
        check("reentry_idx", a_idx, 3'd0);

        // Asynchronous reset between edges mid-scan.
        for (int c = 1; c <= 5; c++) tick();
        check("pre_rst_out", a_out, 8'h02);
        #2;
        sys_rst = 1'b1;
        #1;
        check("arst_out", a_out, 8'h00);
        check("arst_idx", a_idx, 3'd0);
        check("arst_vld", a_vld, 1'b0);
        check("arst_b_out", b_out, 8'h00);
        check("arst_b_wrap", b_wrap, 1'b0);
        tick();
        sys_rst = 1'b0;
        mode = M_DIRECT; sel = 3'd2; sel_vld = 1'b1;
        tick();
        check("post_rst_dir", a_out, 8'h04);
        mode = M_OFF; sel_vld = 1'b0;
        tick();
        check("off2_out", a_out, 8'h00);
        check("off2_idx", a_idx, 3'd0);
        check("off2_vld", a_vld, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
